// File: rtl/key_beep_multi.sv
// Multi-key debouncer with press/release/long-press events and a beeper that
// sounds once for a short press and twice for a long press.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | silent, waiting for a press or long-press event
// BEEP1 | first (or only) beep, BEEP_CYC cycles
// GAP   | silence between the two beeps of a long press
// BEEP2 | second beep of a long press, BEEP_CYC cycles
module key_beep_multi #(
  parameter int KEY_NUM      = 4,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int BEEP_CYC     = 5_000_000,
  parameter int TONE_DIV     = 0
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key,
  input  logic               beep_en,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic               beep
);

  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam int LW = $clog2(LONG_CYC + 1);
  localparam int BW = $clog2(BEEP_CYC);
  localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYC - 1);
  localparam logic [LW-1:0] LONG_SAT  = LW'(LONG_CYC);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYC - 1);
  localparam logic [TW-1:0] TONE_LAST = (TONE_DIV > 0) ? TW'(TONE_DIV - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_BEEP1, S_GAP, S_BEEP2} state_t;

  logic [KEY_NUM-1:0] sync1_q, sync2_q;
  logic [KEY_NUM-1:0] level_q, level_d;
  logic [KEY_NUM-1:0] press_q, press_d;
  logic [KEY_NUM-1:0] release_q, release_d;
  logic [KEY_NUM-1:0] long_q, long_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
    end else begin
      sync1_q   <= key;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          lvl_n, prs_n, rel_n, lng_n;

    always_comb begin
      dcnt_d = '0;
      lvl_n  = level_q[k];
      prs_n  = 1'b0;
      rel_n  = 1'b0;
      // Synced key is active-low; level is active-high.
      if (sync2_q[k] == level_q[k]) begin
        if (dcnt_q == DEB_LAST) begin
          lvl_n = ~level_q[k];
          prs_n = ~level_q[k];
          rel_n = level_q[k];
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end

      lcnt_d = lcnt_q;
      lng_n  = 1'b0;
      if (!level_q[k] || rel_n) begin
        lcnt_d = '0;
      end else if (lcnt_q == LONG_LAST) begin
        lcnt_d = LONG_SAT;
        lng_n  = 1'b1;
      end else if (lcnt_q != LONG_SAT) begin
        lcnt_d = lcnt_q + LW'(1);
      end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        dcnt_q <= '0;
        lcnt_q <= '0;
      end else begin
        dcnt_q <= dcnt_d;
        lcnt_q <= lcnt_d;
      end
    end

    assign level_d[k]   = lvl_n;
    assign press_d[k]   = prs_n;
    assign release_d[k] = rel_n;
    assign long_d[k]    = lng_n;
  end

  state_t        state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          dbl_q, dbl_d;
  logic [TW-1:0] tdiv_q, tdiv_d;
  logic          tone_q, tone_d;
  logic          beep_q, beep_d;
  logic          long_hit, sounding_d, tone_rst;

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    dbl_d    = dbl_q;
    long_hit = beep_en && (|long_q);
    if (!beep_en) begin
      state_d = S_IDLE;
      bcnt_d  = '0;
      dbl_d   = 1'b0;
    end else if (long_hit) begin
      // A long press restarts the sequence from any state.
      state_d = S_BEEP1;
      bcnt_d  = '0;
      dbl_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|press_q) begin
            state_d = S_BEEP1;
            bcnt_d  = '0;
            dbl_d   = 1'b0;
          end
        end
        S_BEEP1: begin
          if (bcnt_q == BEEP_LAST) begin
            bcnt_d  = '0;
            state_d = dbl_q ? S_GAP : S_IDLE;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
        S_GAP: begin
          if (bcnt_q == BEEP_LAST) begin
            bcnt_d  = '0;
            state_d = S_BEEP2;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
        S_BEEP2: begin
          if (bcnt_q == BEEP_LAST) begin
            bcnt_d  = '0;
            state_d = S_IDLE;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          bcnt_d  = '0;
        end
      endcase
    end

    sounding_d = (state_d == S_BEEP1) || (state_d == S_BEEP2);
    tone_rst   = sounding_d && ((state_d != state_q) || long_hit);
    tdiv_d     = tdiv_q;
    tone_d     = tone_q;
    // Each beep starts with the tone low.
    if (!sounding_d || tone_rst) begin
      tdiv_d = '0;
      tone_d = 1'b0;
    end else if (tdiv_q == TONE_LAST) begin
      tdiv_d = '0;
      tone_d = ~tone_q;
    end else begin
      tdiv_d = tdiv_q + TW'(1);
    end
    beep_d = sounding_d && ((TONE_DIV == 0) ? 1'b1 : tone_d);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      dbl_q   <= 1'b0;
      tdiv_q  <= '0;
      tone_q  <= 1'b0;
      beep_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      dbl_q   <= dbl_d;
      tdiv_q  <= tdiv_d;
      tone_q  <= tone_d;
      beep_q  <= beep_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;
  assign beep        = beep_q;

endmodule

// File: tb/tb_key_beep_multi.sv
// Directed bench for key_beep_multi: a constant-level instance and a tone instance
// (TONE_DIV=2) share the key and enable stimulus.
module tb_key_beep_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key;
  logic       beep_en;

  logic [1:0] key_level, key_press, key_release, key_long;
  logic       beep;
  logic [1:0] t_level, t_press, t_release, t_long;
  logic       t_beep;

  int total = 0;
  int bad   = 0;

  always #10 clk = ~clk;

  key_beep_multi #(
    .KEY_NUM(2), .DEBOUNCE_CYC(4), .LONG_CYC(20), .BEEP_CYC(8), .TONE_DIV(0)
  ) u_dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .key(key), .beep_en(beep_en),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .beep(beep)
  );

  key_beep_multi #(
    .KEY_NUM(2), .DEBOUNCE_CYC(4), .LONG_CYC(20), .BEEP_CYC(8), .TONE_DIV(2)
  ) u_tone (
    .sys_clk(clk), .sys_rst_n(rst_n), .key(key), .beep_en(beep_en),
    .key_level(t_level), .key_press(t_press), .key_release(t_release),
    .key_long(t_long), .beep(t_beep)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #50;
    total++;
    if (key_level !== 2'b00) begin
      bad++; $display("FAIL reset_level got=%b exp=00", key_level);
    end
    total++;
    if ({key_press, key_release, key_long} !== 6'b0) begin
      bad++; $display("FAIL reset_events got=%b exp=000000", {key_press, key_release, key_long});
    end
    total++;
    if ({beep, t_beep} !== 2'b00) begin
      bad++; $display("FAIL reset_beep got=%b exp=00", {beep, t_beep});
    end
    #50;
    rst_n = 1'b1;
    repeat (5) tick();
    total++;
    if ({key_level, beep} !== 3'b000) begin
      bad++; $display("FAIL post_reset_idle got=%b exp=000", {key_level, beep});
    end
  endtask

  task automatic test_bounce();
    int press_n = 0;
    int lvl_n   = 0;
    int beep_n  = 0;
    for (int r = 0; r < 3; r++) begin
      for (int h = 0; h < 2; h++) begin
        key[0] = (h == 1);
        for (int c = 0; c < 2; c++) begin
          tick();
          press_n += int'(key_press[0]);
          lvl_n   += int'(key_level[0]);
          beep_n  += int'(beep);
        end
      end
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      press_n += int'(key_press[0]);
      lvl_n   += int'(key_level[0]);
      beep_n  += int'(beep);
    end
    total++;
    if (press_n != 0) begin bad++; $display("FAIL bounce_press got=%0d exp=0", press_n); end
    total++;
    if (lvl_n != 0) begin bad++; $display("FAIL bounce_level got=%0d exp=0", lvl_n); end
    total++;
    if (beep_n != 0) begin bad++; $display("FAIL bounce_beep got=%0d exp=0", beep_n); end
  endtask

  task automatic test_short_press();
    int press_at = -1, press_n = 0, rel_at = -1, rel_n = 0, long_n = 0;
    int beep_first = -1, beep_last = -1, beep_n = 0;
    key[0] = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (key_press[0]) begin press_n++; if (press_at < 0) press_at = t; end
      if (key_release[0]) begin rel_n++; if (rel_at < 0) rel_at = t; end
      long_n += int'(|key_long);
      if (beep) begin beep_n++; if (beep_first < 0) beep_first = t; beep_last = t; end
      if (t == 10) key[0] = 1'b1;
    end
    total++;
    if (press_at != 6 || press_n != 1) begin
      bad++; $display("FAIL short_press at=%0d n=%0d exp at=6 n=1", press_at, press_n);
    end
    total++;
    if (rel_at != 16 || rel_n != 1) begin
      bad++; $display("FAIL short_release at=%0d n=%0d exp at=16 n=1", rel_at, rel_n);
    end
    total++;
    if (long_n != 0) begin bad++; $display("FAIL short_no_long got=%0d exp=0", long_n); end
    total++;
    if (beep_first != 7 || beep_last != 14 || beep_n != 8) begin
      bad++; $display("FAIL short_beep first=%0d last=%0d n=%0d exp 7/14/8", beep_first, beep_last, beep_n);
    end
  endtask

  task automatic test_long_press();
    logic [63:0] obs  = '0;
    logic [63:0] expb = '0;
    int press_at = -1, long_at = -1, long_n = 0, rel_at = -1;
    for (int t = 7; t <= 14; t++) expb[t] = 1'b1;
    for (int t = 27; t <= 34; t++) expb[t] = 1'b1;
    for (int t = 43; t <= 50; t++) expb[t] = 1'b1;
    key[1] = 1'b0;
    for (int t = 1; t <= 63; t++) begin
      tick();
      obs[t] = beep;
      if (key_press[1] && press_at < 0) press_at = t;
      if (key_long[1]) begin long_n++; if (long_at < 0) long_at = t; end
      if (key_release[1] && rel_at < 0) rel_at = t;
      if (t == 40) key[1] = 1'b1;
    end
    total++;
    if (press_at != 6) begin bad++; $display("FAIL long_press_at got=%0d exp=6", press_at); end
    total++;
    if (long_at != 26 || long_n != 1) begin
      bad++; $display("FAIL long_event at=%0d n=%0d exp at=26 n=1", long_at, long_n);
    end
    total++;
    if (rel_at != 46) begin bad++; $display("FAIL long_release_at got=%0d exp=46", rel_at); end
    total++;
    if (obs !== expb) begin
      bad++; $display("FAIL long_beep_pattern got=%h exp=%h", obs, expb);
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] obs  = '0;
    logic [39:0] expb = '0;
    int p0_at = -1, p1_at = -1;
    for (int t = 7; t <= 14; t++) expb[t] = 1'b1;
    key[0] = 1'b0;
    for (int t = 1; t <= 39; t++) begin
      tick();
      obs[t] = beep;
      if (key_press[0] && p0_at < 0) p0_at = t;
      if (key_press[1] && p1_at < 0) p1_at = t;
      if (t == 3)  key[1] = 1'b0;
      if (t == 12) key[0] = 1'b1;
      if (t == 15) key[1] = 1'b1;
    end
    total++;
    if (p0_at != 6) begin bad++; $display("FAIL busy_press0 got=%0d exp=6", p0_at); end
    total++;
    if (p1_at != 9) begin bad++; $display("FAIL busy_press1 got=%0d exp=9", p1_at); end
    total++;
    if (obs !== expb) begin
      bad++; $display("FAIL busy_beep_pattern got=%h exp=%h", obs, expb);
    end
  endtask

  task automatic test_tone();
    logic [31:0] obs  = '0;
    logic [31:0] expb = '0;
    int p_n = 0, r_n = 0, l_n = 0, lvl10 = 0, plain_n = 0;
    expb[9] = 1'b1; expb[10] = 1'b1; expb[13] = 1'b1; expb[14] = 1'b1;
    key[0] = 1'b0;
    for (int t = 1; t <= 31; t++) begin
      tick();
      obs[t] = t_beep;
      p_n += int'(t_press[0]);
      r_n += int'(t_release[0]);
      l_n += int'(|t_long);
      plain_n += int'(beep);
      if (t == 10) begin lvl10 = int'(t_level[0]); key[0] = 1'b1; end
    end
    total++;
    if (obs !== expb) begin
      bad++; $display("FAIL tone_pattern got=%h exp=%h", obs, expb);
    end
    total++;
    if (p_n != 1 || r_n != 1 || l_n != 0 || lvl10 != 1) begin
      bad++; $display("FAIL tone_events press=%0d rel=%0d long=%0d lvl=%0d exp 1/1/0/1", p_n, r_n, l_n, lvl10);
    end
    total++;
    if (plain_n != 8) begin bad++; $display("FAIL tone_plain_beep got=%0d exp=8", plain_n); end
  endtask

  task automatic test_mute_reset();
    int p_n = 0, r_n = 0, b_n = 0;
    beep_en = 1'b0;
    key[0]  = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      p_n += int'(key_press[0]);
      r_n += int'(key_release[0]);
      b_n += int'(beep) + int'(t_beep);
      if (t == 10) key[0] = 1'b1;
    end
    beep_en = 1'b1;
    total++;
    if (p_n != 1 || r_n != 1) begin
      bad++; $display("FAIL mute_events press=%0d rel=%0d exp 1/1", p_n, r_n);
    end
    total++;
    if (b_n != 0) begin bad++; $display("FAIL mute_beep got=%0d exp=0", b_n); end

    repeat (3) tick();
    key[0] = 1'b0;
    repeat (10) tick();
    total++;
    if (beep !== 1'b1) begin bad++; $display("FAIL midbeep_on got=%b exp=1", beep); end
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({beep, t_beep} !== 2'b00) begin
      bad++; $display("FAIL async_reset_beep got=%b exp=00", {beep, t_beep});
    end
    total++;
    if (key_level !== 2'b00) begin
      bad++; $display("FAIL async_reset_level got=%b exp=00", key_level);
    end
    key = 2'b11;
    #5;
    rst_n = 1'b1;
    repeat (20) tick();
    total++;
    if ({key_level, beep} !== 3'b000) begin
      bad++; $display("FAIL after_reset_idle got=%b exp=000", {key_level, beep});
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    key     = 2'b11;
    beep_en = 1'b1;
    test_reset();
    test_bounce();
    test_short_press();
    test_long_press();
    test_back_to_back();
    test_tone();
    test_mute_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
